// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared types and address-map constants for the perf_counter_mmio block.
//   perf_state_t      : bus response FSM states (IDLE, RESP)
//   PERF_ADDR_STRIDE  : byte distance between consecutive counters
//   PERF_INDEX_LSB/MSB: bit range of the byte address that selects a counter
// -----------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } perf_state_t;

    localparam int PERF_ADDR_STRIDE = 4;
    localparam int PERF_INDEX_LSB   = 2;
    localparam int PERF_INDEX_MSB   = 7;

endpackage

// File: rtl/perf_counter_mmio_if.sv
// -----------------------------------------------------------------------------
// perf_counter_mmio_if
// CPU data-memory bus as seen by the counter bank.
//   address : byte address of the access
//   read    : read request, held until resp
//   write   : write request, held until resp
//   wdata   : write data (contents do not matter to the counter bank)
//   rdata   : read data returned with resp
//   resp    : single-cycle response strobe
// modport master : requester side (CPU / arbiter)
// modport slave  : responder side (counter bank)
// -----------------------------------------------------------------------------
interface perf_counter_mmio_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;

    modport master (
        output address,
        output read,
        output write,
        output wdata,
        input  rdata,
        input  resp
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  wdata,
        output rdata,
        output resp
    );

endinterface

// File: rtl/perf_event_counter.sv
// -----------------------------------------------------------------------------
// perf_event_counter
// One event counter: counts rising edges of a level event strobe.
// Build option: define PERF_SATURATE_EN to make the counter stick at all-ones
// instead of wrapping to zero.
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset (clears counter and edge register)
//   event_in : level event strobe
//   clear    : clear request from a bus write; wins over a same-edge increment
//   count    : current counter value
// -----------------------------------------------------------------------------
module perf_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             event_in,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic             prev_q;
    logic             prev_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rise;

    always_comb begin
        prev_d  = event_in;
        rise    = event_in & ~prev_q;
        count_d = count_q;
        // The edge register always tracks the input, even when a clear wins,
        // so an event already high at the clear edge is not counted again.
        if (clear) begin
            count_d = '0;
        end else if (rise) begin
`ifdef PERF_SATURATE_EN
            if (count_q != {WIDTH{1'b1}}) begin
                count_d = count_q + WIDTH'(1);
            end
`else
            count_d = count_q + WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/perf_counter_mmio.sv
// -----------------------------------------------------------------------------
// perf_counter_mmio
// Memory-mapped bank of NUM_EVENTS edge-counting event counters on the CPU
// data-memory bus. A load from BASE_ADDR + 4*i returns counter i zero-extended
// to 32 bits; a store to the same address clears it (store data is ignored).
// Build option: PERF_SATURATE_EN (saturating instead of wrapping counters,
// implemented inside perf_event_counter).
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   events  : level event strobes, one per counter
//   mem     : bus slave port (address/read/write/wdata in, rdata/resp out)
// -----------------------------------------------------------------------------
module perf_counter_mmio
    import perf_pkg::*;
#(
    parameter int          NUM_EVENTS = 8,
    parameter int          WIDTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] events,
    perf_counter_mmio_if.slave    mem
);

    localparam int IDX_W = PERF_INDEX_MSB - PERF_INDEX_LSB + 1;

    logic [WIDTH-1:0]      counts [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] clear;
    logic [IDX_W-1:0]      index;
    logic                  hit;
    logic [WIDTH-1:0]      sel_count;

    perf_state_t           state_q;
    perf_state_t           state_d;
    logic [31:0]           rdata_q;
    logic [31:0]           rdata_d;

    // Counter bank
    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
        perf_event_counter #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk      (clk),
            .reset_n  (reset_n),
            .event_in (events[g]),
            .clear    (clear[g]),
            .count    (counts[g])
        );
    end

    // Address decode: page match, word aligned, and index inside the bank.
    // The index is widened by one bit so NUM_EVENTS = 64 still compares cleanly.
    assign index = mem.address[PERF_INDEX_MSB:PERF_INDEX_LSB];
    assign hit   = (mem.address[31:PERF_INDEX_MSB+1] == BASE_ADDR[31:PERF_INDEX_MSB+1])
                && (mem.address[PERF_INDEX_LSB-1:0] == '0)
                && ({1'b0, index} < (IDX_W+1)'(NUM_EVENTS));

    // Read mux over the pre-update counter values
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (index == IDX_W'(i)) begin
                sel_count = counts[i];
            end
        end
    end

    // Response FSM: accept in IDLE, respond for exactly one cycle in RESP.
    // Write takes precedence when read and write are both asserted.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        clear   = '0;
        case (state_q)
            IDLE: begin
                if (hit && (mem.read || mem.write)) begin
                    state_d = RESP;
                    if (mem.write) begin
                        clear = NUM_EVENTS'(1) << index;
                    end else begin
                        rdata_d              = '0;
                        rdata_d[WIDTH-1:0]   = sel_count;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem.resp  = (state_q == RESP);
    assign mem.rdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_mmio
// Two counter banks share clock and reset: dut8 (NUM_EVENTS=8, WIDTH=16) and
// dut4 (NUM_EVENTS=8, WIDTH=4, for wrap/saturation). A reference model counts
// rising event edges per counter with plain integers and tracks which bus
// requests are accepted; outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_perf_counter_mmio;
    import perf_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  ev      [2];
    logic [31:0] addr_t  [2];
    logic [31:0] wdata_t [2];
    logic        rd_t    [2];
    logic        wr_t    [2];
    logic [31:0] rdata_w [2];
    logic        resp_w  [2];

    int checks   = 0;
    int failures = 0;

    perf_counter_mmio_if bus8 ();
    perf_counter_mmio_if bus4 ();

    assign bus8.address = addr_t[0];
    assign bus8.read    = rd_t[0];
    assign bus8.write   = wr_t[0];
    assign bus8.wdata   = wdata_t[0];
    assign bus4.address = addr_t[1];
    assign bus4.read    = rd_t[1];
    assign bus4.write   = wr_t[1];
    assign bus4.wdata   = wdata_t[1];
    assign rdata_w[0]   = bus8.rdata;
    assign resp_w[0]    = bus8.resp;
    assign rdata_w[1]   = bus4.rdata;
    assign resp_w[1]    = bus4.resp;

    perf_counter_mmio #(.NUM_EVENTS(8), .WIDTH(16), .BASE_ADDR(BASE)) dut8 (
        .clk(clk), .reset_n(reset_n), .events(ev[0]), .mem(bus8));
    perf_counter_mmio #(.NUM_EVENTS(8), .WIDTH(4), .BASE_ADDR(BASE)) dut4 (
        .clk(clk), .reset_n(reset_n), .events(ev[1]), .mem(bus4));

    // ---------------- reference model ----------------
    int unsigned m_cnt   [2][8];
    bit          m_prev  [2][8];
    bit          m_busy  [2] = '{1'b0, 1'b0};
    logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
    int          m_w     [2] = '{16, 4};

    function automatic bit m_hit(logic [31:0] a);
        return (a[31:8] == BASE[31:8]) && (a[1:0] == 2'b00) && (a[7:2] < 6'd8);
    endfunction

    task automatic model_step(int d);
        bit acc;
        int idx;
        int unsigned mx;
        acc = !m_busy[d] && m_hit(addr_t[d]) && (rd_t[d] || wr_t[d]);
        idx = int'(addr_t[d][7:2]);
        mx  = (32'd1 << m_w[d]) - 1;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                m_cnt[d][i]  = 0;
                m_prev[d][i] = 1'b0;
            end
            m_busy[d]  = 1'b0;
            m_rdata[d] = 32'd0;
        end else begin
            if (acc && !wr_t[d]) m_rdata[d] = m_cnt[d][idx];
            for (int i = 0; i < 8; i++) begin
                if (acc && wr_t[d] && i == idx) begin
                    m_cnt[d][i] = 0;
                end else if (ev[d][i] && !m_prev[d][i]) begin
`ifdef PERF_SATURATE_EN
                    if (m_cnt[d][i] < mx) m_cnt[d][i] = m_cnt[d][i] + 1;
`else
                    m_cnt[d][i] = (m_cnt[d][i] + 1) & mx;
`endif
                end
                m_prev[d][i] = ev[d][i];
            end
            m_busy[d] = acc;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    // ---------------- helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("resp%0d", d), 32'(resp_w[d]), 32'(m_busy[d]));
            chk($sformatf("rdata%0d", d), rdata_w[d], m_rdata[d]);
        end
    endtask

    task automatic bus_op(int d, logic [31:0] a, bit w, output logic [31:0] data);
        int lat;
        addr_t[d]  = a;
        wr_t[d]    = w;
        rd_t[d]    = !w;
        wdata_t[d] = $urandom;
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (resp_w[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
        rd_t[d] = 1'b0;
        wr_t[d] = 1'b0;
        data    = rdata_w[d];
        chk("latency", 32'(lat), 32'd1);
        tick();
    endtask

    task automatic hold_nohit(int d, logic [31:0] a, bit r, bit w, int n);
        addr_t[d] = a;
        rd_t[d]   = r;
        wr_t[d]   = w;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("nohit_resp", 32'(resp_w[d]), 32'd0);
        end
        rd_t[d] = 1'b0;
        wr_t[d] = 1'b0;
    endtask

    task automatic pulses(int d, int bitn, int n);
        for (int k = 0; k < n; k++) begin
            ev[d][bitn] = 1'b1;
            tick();
            ev[d][bitn] = 1'b0;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] data;
        int unsigned snap [8];
        int          d;
        int          idx;
        bit          w;

        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = '0; addr_t[i] = '0; wdata_t[i] = '0; rd_t[i] = 1'b0; wr_t[i] = 1'b0;
        end
        repeat (3) tick();
        chk("rst_resp", 32'(resp_w[0]), 32'd0);
        chk("rst_rdata", rdata_w[0], 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: long pulse then short pulse counts twice
        ev[0][0] = 1'b1;
        repeat (5) tick();
        ev[0][0] = 1'b0;
        tick();
        ev[0][0] = 1'b1;
        tick();
        ev[0][0] = 1'b0;
        tick();
        bus_op(0, BASE, 1'b0, data);
        chk("t1_cnt0", data, 32'd2);

        // 2: event held high through reset release counts once
        ev[0][3] = 1'b1;
        reset_n  = 1'b0;
        repeat (2) tick();
        reset_n  = 1'b1;
        repeat (3) tick();
        bus_op(0, BASE + 3 * PERF_ADDR_STRIDE, 1'b0, data);
        chk("t2_cnt3", data, 32'd1);
        ev[0][3] = 1'b0;
        bus_op(0, BASE, 1'b0, data);
        chk("t2_cnt0_cleared", data, 32'd0);

        // 3: clear wins over a same-edge increment; rdata untouched by write
        pulses(0, 1, 5);
        bus_op(0, BASE + 32'h4, 1'b0, data);
        chk("t3_cnt1_pre", data, 32'd5);
        ev[0][1] = 1'b1;
        bus_op(0, BASE + 32'h4, 1'b1, data);
        chk("t3_rdata_hold", data, 32'd5);
        ev[0][1] = 1'b0;
        tick();
        bus_op(0, BASE + 32'h4, 1'b0, data);
        chk("t3_cnt1_post", data, 32'd0);

        // 4: 16 pulses on a 4-bit counter
        pulses(1, 2, 16);
        bus_op(1, BASE + 32'h8, 1'b0, data);
`ifdef PERF_SATURATE_EN
        chk("t4_wrap", data, 32'd15);
`else
        chk("t4_wrap", data, 32'd0);
`endif

        // 5: non-hit requests are ignored
        pulses(0, 4, 3);
        pulses(0, 5, 1);
        for (int i = 0; i < 8; i++) snap[i] = m_cnt[0][i];
        hold_nohit(0, 32'hFFFF_FF20, 1'b1, 1'b0, 4);
        hold_nohit(0, 32'hFFFF_FF01, 1'b0, 1'b1, 4);
        hold_nohit(0, 32'h0000_0000, 1'b1, 1'b1, 4);
        for (int i = 0; i < 8; i++) begin
            bus_op(0, BASE + 32'(i * PERF_ADDR_STRIDE), 1'b0, data);
            chk($sformatf("t5_cnt%0d", i), data, snap[i]);
        end

        // random traffic against the model
        repeat (80) begin
            ev[0] = 8'($urandom);
            ev[1] = 8'($urandom);
            tick();
            if ($urandom_range(0, 2) == 0) begin
                d   = int'($urandom_range(0, 1));
                idx = int'($urandom_range(0, 7));
                w   = ($urandom_range(0, 3) == 0);
                bus_op(d, BASE + 32'(idx * PERF_ADDR_STRIDE), w, data);
                if (!w) chk("rnd_read", data, m_rdata[d]);
            end else if ($urandom_range(0, 5) == 0) begin
                hold_nohit(0, BASE + 32'h20 + 32'($urandom_range(0, 7) * 4), 1'b1, 1'b0, 2);
            end
        end
        ev[0] = '0;
        ev[1] = '0;
        tick();

        // 6: reset during RESP drops the response and clears everything
        addr_t[0] = BASE;
        rd_t[0]   = 1'b1;
        tick();
        chk("t6_resp_before", 32'(resp_w[0]), 32'd1);
        reset_n = 1'b0;
        rd_t[0] = 1'b0;
        tick();
        chk("t6_resp_reset", 32'(resp_w[0]), 32'd0);
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                bus_op(k, BASE + 32'(i * PERF_ADDR_STRIDE), 1'b0, data);
                chk($sformatf("t6_zero%0d_%0d", k, i), data, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
